// File: rtl/pingpong_rd_sched.sv
// -----------------------------------------------------------------------------
// pingpong_rd_sched
//
// Read-side scheduler for the two FIR ping-pong banks. Each bank has two
// owners after the FIR writer completes it: the PL log-mel engine (streamed
// here, released when the stream drains) and the PS SD-carry path (released
// by a rising edge on ps_done). A bank is free again only when both owners
// have released it. A completion arriving for a bank that is still owned is
// dropped and counted.
//
// Parameters
//   DEPTH   words per bank, read addresses 0..DEPTH-1
//   AW      address width
//   RD_LAT  RAM read latency in cycles (1..3)
//
// Ports
//   clk_100m            100 MHz system clock
//   rst                 synchronous active-high reset
//   wr_done, wr_bank    one-cycle completion pulse and the bank it refers to
//   ps_done             asynchronous PS carry-done level
//   rd_ready            PL consumer accepts an address issue this cycle
//   en_rd1, en_rd2      bank read enables (combinational from state/rd_ready)
//   addr_rd             read address
//   rd_vld, rd_last     read data valid / last word, RD_LAT after issue
//   pl_start            one-cycle pulse at the start of each stream
//   ps_full1, ps_full2  bank owned by PS
//   bank_busy           per bank: PL or PS still owns it
//   overflow, drop_cnt  sticky drop flag and saturating drop counter
// -----------------------------------------------------------------------------
module pingpong_rd_sched #(
  parameter int DEPTH  = 35500,
  parameter int AW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk_100m,
  input  logic          rst,
  input  logic          wr_done,
  input  logic          wr_bank,
  input  logic          ps_done,
  input  logic          rd_ready,
  output logic          en_rd1,
  output logic          en_rd2,
  output logic [AW-1:0] addr_rd,
  output logic          rd_vld,
  output logic          rd_last,
  output logic          pl_start,
  output logic          ps_full1,
  output logic          ps_full2,
  output logic [1:0]    bank_busy,
  output logic          overflow,
  output logic [7:0]    drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } pl_state_e;

  pl_state_e         state;
  logic              cur;        // bank being streamed
  logic              pl_nb;      // bank PL prefers next
  logic              ps_nb;      // bank PS is expected to release next
  logic [1:0]        drain_q;
  logic [1:0]        pl_pend;
  logic [1:0]        ps_pend;
  logic              ps_s1, ps_s2, ps_s3;
  logic [RD_LAT-1:0] vld_pipe;
  logic [RD_LAT-1:0] last_pipe;

  logic       issue;
  logic       issue_last;
  logic       ps_edge;
  logic       pl_rel_any;
  logic       wr_accept;
  logic       wr_drop;
  logic       ps_nb_nx;
  logic [1:0] pl_rel;
  logic [1:0] ps_rel;
  logic [1:0] pl_pend_nx;
  logic [1:0] ps_pend_nx;

  // Issue is decoded straight from rd_ready so the consumer's backpressure
  // takes effect in the same cycle without a skid buffer.
  assign issue      = (state == READ) && rd_ready;
  assign issue_last = issue && (addr_rd == AW'(DEPTH - 1));
  assign en_rd1     = issue && !cur;
  assign en_rd2     = issue && cur;

  assign ps_edge    = ps_s2 && !ps_s3;
  assign pl_rel_any = (state == DRAIN) && (drain_q == 2'(RD_LAT - 1));

  assign rd_vld   = vld_pipe[RD_LAT-1];
  assign rd_last  = last_pipe[RD_LAT-1];
  assign ps_full1 = ps_pend[0];
  assign ps_full2 = ps_pend[1];

  // Ownership next-state: releases are applied first, so a completion landing
  // on a bank in the same cycle it is freed is accepted.
  always_comb begin
    // NOTE: every signal gets a default before any branch; otherwise a path
    // that skips an assignment infers a latch.
    pl_rel   = '0;
    ps_rel   = '0;
    ps_nb_nx = ps_nb;
    if (pl_rel_any) pl_rel[cur] = 1'b1;
    if (ps_edge) begin
      if (ps_pend[ps_nb]) begin
        ps_rel[ps_nb] = 1'b1;
        ps_nb_nx      = !ps_nb;
      end else if (ps_pend[!ps_nb]) begin
        ps_rel[!ps_nb] = 1'b1;
        ps_nb_nx       = ps_nb;
      end
    end
    pl_pend_nx = pl_pend & ~pl_rel;
    ps_pend_nx = ps_pend & ~ps_rel;
    wr_accept  = wr_done && !(pl_pend_nx[wr_bank] || ps_pend_nx[wr_bank]);
    wr_drop    = wr_done && !wr_accept;
    if (wr_accept) begin
      pl_pend_nx[wr_bank] = 1'b1;
      ps_pend_nx[wr_bank] = 1'b1;
    end
  end

  // Ownership bits, PS synchronizer and drop accounting.
  always_ff @(posedge clk_100m) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      ps_s1     <= 1'b0;
      ps_s2     <= 1'b0;
      ps_s3     <= 1'b0;
      pl_pend   <= '0;
      ps_pend   <= '0;
      ps_nb     <= 1'b0;
      bank_busy <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      ps_s1     <= ps_done;
      ps_s2     <= ps_s1;
      ps_s3     <= ps_s2;
      pl_pend   <= pl_pend_nx;
      ps_pend   <= ps_pend_nx;
      ps_nb     <= ps_nb_nx;
      bank_busy <= pl_pend_nx | ps_pend_nx;
      if (wr_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // PL stream FSM with the read-latency pipeline for rd_vld / rd_last.
  always_ff @(posedge clk_100m) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= 1'b0;
      pl_nb     <= 1'b0;
      addr_rd   <= '0;
      drain_q   <= '0;
      pl_start  <= 1'b0;
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      pl_start     <= 1'b0;
      vld_pipe[0]  <= issue;
      last_pipe[0] <= issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      case (state)
        IDLE: begin
          addr_rd <= '0;
          drain_q <= '0;
          if (pl_pend[pl_nb]) begin
            cur      <= pl_nb;
            pl_start <= 1'b1;
            state    <= READ;
          end else if (pl_pend[!pl_nb]) begin
            cur      <= !pl_nb;
            pl_start <= 1'b1;
            state    <= READ;
          end
        end
        READ: begin
          if (issue_last) begin
            addr_rd <= '0;
            state   <= DRAIN;
          end else if (issue) begin
            addr_rd <= addr_rd + 1'b1;
          end
        end
        DRAIN: begin
          // Hold the bank until the last word has come out of the RAM.
          if (pl_rel_any) begin
            pl_nb <= !cur;
            state <= IDLE;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_rd_sched.sv
// -----------------------------------------------------------------------------
// tb_pingpong_rd_sched
//
// Directed bench for pingpong_rd_sched with DEPTH=8, RD_LAT=1. The stimulus
// process pushes the expected address issues and read-valid words of each
// stream into queues; a monitor running on the falling clock edge pops and
// compares them whenever the DUT issues an address or presents rd_vld.
// Ownership and drop status are checked directly by the stimulus process.
// -----------------------------------------------------------------------------
module tb_pingpong_rd_sched;

  localparam int DEPTH  = 8;
  localparam int AW     = 16;
  localparam int RD_LAT = 1;

  logic          clk_100m = 1'b0;
  logic          rst      = 1'b1;
  logic          wr_done  = 1'b0;
  logic          wr_bank  = 1'b0;
  logic          ps_done  = 1'b0;
  logic          rd_ready = 1'b1;
  logic          en_rd1, en_rd2;
  logic [AW-1:0] addr_rd;
  logic          rd_vld, rd_last, pl_start, ps_full1, ps_full2;
  logic [1:0]    bank_busy;
  logic          overflow;
  logic [7:0]    drop_cnt;

  pingpong_rd_sched #(.DEPTH(DEPTH), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk_100m  (clk_100m),
    .rst       (rst),
    .wr_done   (wr_done),
    .wr_bank   (wr_bank),
    .ps_done   (ps_done),
    .rd_ready  (rd_ready),
    .en_rd1    (en_rd1),
    .en_rd2    (en_rd2),
    .addr_rd   (addr_rd),
    .rd_vld    (rd_vld),
    .rd_last   (rd_last),
    .pl_start  (pl_start),
    .ps_full1  (ps_full1),
    .ps_full2  (ps_full2),
    .bank_busy (bank_busy),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk_100m = ~clk_100m;

  typedef struct packed {
    logic          bank;
    logic [AW-1:0] addr;
  } issue_t;

  issue_t issue_q[$];
  logic   vld_q[$];
  int     n_checks = 0;
  int     n_errors = 0;
  logic   armed    = 1'b0;
  logic   exp_vld  = 1'b0;
  logic   mon_iss;
  issue_t mon_exp;
  logic   mon_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic pulse_wr(input logic bank);
    wr_done = 1'b1;
    wr_bank = bank;
    tick();
    wr_done = 1'b0;
  endtask

  // Rising edge on ps_done, held long enough to pass the synchronizer, then
  // low long enough that the next call produces a fresh edge.
  task automatic ps_pulse();
    ps_done = 1'b1;
    repeat (4) tick();
    ps_done = 1'b0;
    repeat (3) tick();
  endtask

  task automatic expect_stream(input logic bank, input int n_iss, input int n_vld);
    for (int i = 0; i < n_iss; i++) issue_q.push_back('{bank: bank, addr: AW'(i)});
    for (int i = 0; i < n_vld; i++) vld_q.push_back(i == DEPTH - 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en_rd1"},    en_rd1,    0);
    check({tag, "_en_rd2"},    en_rd2,    0);
    check({tag, "_addr_rd"},   addr_rd,   0);
    check({tag, "_rd_vld"},    rd_vld,    0);
    check({tag, "_rd_last"},   rd_last,   0);
    check({tag, "_pl_start"},  pl_start,  0);
    check({tag, "_ps_full1"},  ps_full1,  0);
    check({tag, "_ps_full2"},  ps_full2,  0);
    check({tag, "_bank_busy"}, bank_busy, 0);
    check({tag, "_overflow"},  overflow,  0);
    check({tag, "_drop_cnt"},  drop_cnt,  0);
  endtask

  // Monitor: compares issues and read-valid words against the scoreboard and
  // checks that rd_vld is the issue strobe delayed by one cycle.
  always @(negedge clk_100m) begin
    if (armed) begin
      mon_iss = en_rd1 | en_rd2;
      check("rd_vld_timing", rd_vld, exp_vld);
      check("en_rd_onehot", en_rd1 & en_rd2, 0);
      if (!rd_vld) check("rd_last_without_vld", rd_last, 0);
      if (mon_iss) begin
        if (issue_q.size() == 0) begin
          check("unexpected_issue", 1, 0);
        end else begin
          mon_exp = issue_q.pop_front();
          check("issue_bank", en_rd2, mon_exp.bank);
          check("issue_addr", addr_rd, mon_exp.addr);
        end
      end
      if (rd_vld) begin
        if (vld_q.size() == 0) begin
          check("unexpected_rd_vld", 1, 0);
        end else begin
          mon_last = vld_q.pop_front();
          check("rd_last", rd_last, mon_last);
        end
      end
      exp_vld = mon_iss & ~rst;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    repeat (3) tick();
    armed = 1'b1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Test 1: single stream on bank0 with rd_ready stuck high.
    expect_stream(1'b0, DEPTH, DEPTH);
    pulse_wr(1'b0);                                 // now t+1
    check("t1_ps_full1", ps_full1, 1);
    check("t1_ps_full2", ps_full2, 0);
    check("t1_busy", bank_busy, 2'b01);
    check("t1_no_start_yet", pl_start, 0);
    check("t1_no_issue_yet", en_rd1, 0);
    tick();                                         // t+2
    check("t1_pl_start", pl_start, 1);
    check("t1_en_rd1", en_rd1, 1);
    check("t1_addr0", addr_rd, 0);
    tick();                                         // t+3
    check("t1_pl_start_pulse", pl_start, 0);
    repeat (8) tick();                              // t+11
    check("t1_busy_ps_only", bank_busy, 2'b01);
    check("t1_ps_full1_held", ps_full1, 1);
    ps_pulse();
    check("t1_ps_full1_clr", ps_full1, 0);
    check("t1_busy_free", bank_busy, 2'b00);

    // Test 2: rd_ready toggling 1,0,1,0,... during the stream.
    expect_stream(1'b0, DEPTH, DEPTH);
    pulse_wr(1'b0);                                 // t+1
    tick();                                         // t+2
    for (int i = 0; i < 2 * DEPTH; i++) begin
      rd_ready = (i % 2 == 0);
      tick();
    end
    rd_ready = 1'b1;                                // t+18
    check("t2_busy_ps_only", bank_busy, 2'b01);
    ps_pulse();
    check("t2_busy_free", bank_busy, 2'b00);

    // Test 3: completion on an owned bank is dropped; counter saturates.
    expect_stream(1'b0, DEPTH, DEPTH);
    pulse_wr(1'b0);                                 // t+1
    tick();                                         // t+2
    pulse_wr(1'b0);                                 // t+3, dropped
    check("t3_overflow", overflow, 1);
    check("t3_drop_cnt1", drop_cnt, 1);
    check("t3_busy", bank_busy, 2'b01);
    check("t3_ps_full2", ps_full2, 0);
    repeat (8) tick();                              // t+11
    wr_done = 1'b1;
    wr_bank = 1'b0;
    repeat (299) tick();
    wr_done = 1'b0;
    check("t3_drop_sat", drop_cnt, 255);
    check("t3_overflow_held", overflow, 1);
    check("t3_busy_after_drops", bank_busy, 2'b01);
    ps_pulse();
    check("t3_busy_free", bank_busy, 2'b00);
    check("t3_overflow_sticky", overflow, 1);
    rst = 1'b1;
    tick();
    check("t3_rst_overflow", overflow, 0);
    check("t3_rst_drop_cnt", drop_cnt, 0);
    rst = 1'b0;

    // Test 4: both banks written; bank1 follows after a one-cycle IDLE.
    expect_stream(1'b0, DEPTH, DEPTH);
    expect_stream(1'b1, DEPTH, DEPTH);
    pulse_wr(1'b0);                                 // t+1
    pulse_wr(1'b1);                                 // t+2
    check("t4_busy_both", bank_busy, 2'b11);
    check("t4_ps_full2", ps_full2, 1);
    repeat (9) tick();                              // t+11, IDLE
    check("t4_idle_no_en_rd2", en_rd2, 0);
    check("t4_idle_no_start", pl_start, 0);
    check("t4_busy_idle", bank_busy, 2'b11);
    tick();                                         // t+12
    check("t4_start2", pl_start, 1);
    check("t4_en_rd2", en_rd2, 1);
    check("t4_addr0", addr_rd, 0);
    repeat (9) tick();                              // t+21
    check("t4_busy_ps_both", bank_busy, 2'b11);
    ps_pulse();
    check("t4_ps_full1_first", ps_full1, 0);
    check("t4_ps_full2_still", ps_full2, 1);
    ps_pulse();
    check("t4_ps_full2_clr", ps_full2, 0);
    check("t4_busy_free", bank_busy, 2'b00);

    // Test 5: PS release and new completion on the same bank, same cycle.
    expect_stream(1'b0, DEPTH, DEPTH);
    pulse_wr(1'b0);
    repeat (10) tick();                             // bank0 PS-only owned
    expect_stream(1'b0, DEPTH, DEPTH);
    ps_done = 1'b1;
    repeat (2) tick();                              // edge visible now
    pulse_wr(1'b0);                                 // release + write
    check("t5_no_overflow", overflow, 0);
    check("t5_no_drop", drop_cnt, 0);
    check("t5_ps_full1", ps_full1, 1);
    check("t5_busy", bank_busy, 2'b01);
    repeat (10) tick();
    ps_done = 1'b0;
    repeat (3) tick();
    ps_pulse();
    check("t5_busy_free", bank_busy, 2'b00);

    // Test 6: reset in the cycle address 4 is issued, then restart.
    expect_stream(1'b0, 5, 4);
    pulse_wr(1'b0);                                 // t+1
    repeat (5) tick();                              // t+6
    check("t6_addr4", addr_rd, 4);
    check("t6_en_rd1", en_rd1, 1);
    rst = 1'b1;
    tick();
    check_reset_outputs("t6");
    rst = 1'b0;
    expect_stream(1'b0, DEPTH, DEPTH);
    pulse_wr(1'b0);                                 // t+1
    tick();                                         // t+2
    check("t6_restart_start", pl_start, 1);
    check("t6_restart_addr0", addr_rd, 0);
    repeat (9) tick();
    ps_pulse();
    check("t6_busy_free", bank_busy, 2'b00);

    repeat (3) tick();
    check("issue_q_empty", issue_q.size(), 0);
    check("vld_q_empty", vld_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
